// File: rtl/hack_pkg.sv
// hack_pkg: shared constants for the Hack CPU slice.
// Instruction field positions, jump-bit indices, datapath widths and the
// jump-condition helper used by hack_cpu.
package hack_pkg;

    localparam int WIDTH  = 16;
    localparam int AWIDTH = 15;

    // Instruction field bit positions
    localparam int OP_C    = 15;
    localparam int BIT_A   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int BIT_DA  = 5;
    localparam int BIT_DD  = 4;
    localparam int BIT_DM  = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    // Positions inside the 3-bit jump field
    localparam int J_LT_BIT = 2;
    localparam int J_EQ_BIT = 1;
    localparam int J_GT_BIT = 0;

    typedef enum logic {
        INSTR_A = 1'b0,
        INSTR_C = 1'b1
    } instr_kind_e;

    // True when the ALU flags satisfy any of the requested jump conditions.
    function automatic logic jump_taken(input logic [2:0] jbits,
                                        input logic       zr,
                                        input logic       ng);
        return (jbits[J_LT_BIT] & ng) |
               (jbits[J_EQ_BIT] & zr) |
               (jbits[J_GT_BIT] & ~zr & ~ng);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// hack_alu: standard Hack ALU.
// Optional zero/negate on each operand, add or AND, optional negate of the
// result; zr flags a zero result and ng a negative one.
module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_f;

    // Operand conditioning, function select and output negation.
    always_comb begin
        w_x = zx ? '0 : x;
        w_x = nx ? ~w_x : w_x;
        w_y = zy ? '0 : y;
        w_y = ny ? ~w_y : w_y;
        w_f = f ? (w_x + w_y) : (w_x & w_y);
        out = no ? ~w_f : w_f;
        zr  = (out == '0);
        ng  = out[WIDTH-1];
    end

endmodule

// File: rtl/hack_pc.sv
// hack_pc: program counter with async active-low reset.
// When enabled it either loads a jump target or increments, wrapping at the
// top of the address space; when disabled it holds.
module hack_pc #(
    parameter int AWIDTH = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [AWIDTH-1:0] i_din,
    output logic [AWIDTH-1:0] o_pc
);

    logic [AWIDTH-1:0] r_pc;

    // Load the jump target or step to the next sequential address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_en) begin
            r_pc <= i_load ? i_din : (r_pc + {{(AWIDTH-1){1'b0}}, 1'b1});
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU core (decode, A/D/PC registers, ALU).
// Optional feature macro HACK_CPU_STALL_EN: when defined, instr_valid low
// freezes A, D and pc and suppresses writeM; when undefined instr_valid is
// ignored and every clock edge out of reset executes an instruction.
import hack_pkg::*;

module hack_cpu #(
    parameter int WIDTH  = hack_pkg::WIDTH,
    parameter int AWIDTH = hack_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  instruction,
    input  logic              instr_valid,
    input  logic [WIDTH-1:0]  inM,
    output logic [WIDTH-1:0]  outM,
    output logic              writeM,
    output logic [AWIDTH-1:0] addressM,
    output logic [AWIDTH-1:0] pc
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;

    instr_kind_e      w_kind;
    logic             w_isC;
    logic             w_exec;
    logic [5:0]       w_ctrl;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_aluOut;
    logic             w_zr;
    logic             w_ng;
    logic             w_jump;

`ifdef HACK_CPU_STALL_EN
    assign w_exec = instr_valid;
`else
    logic w_unused_valid;
    assign w_unused_valid = instr_valid;
    assign w_exec = 1'b1;
`endif

    // Decode: A-instructions force ALU controls to zero so outM is deterministic.
    always_comb begin
        w_kind = instr_kind_e'(instruction[OP_C]);
        w_isC  = (w_kind == INSTR_C);
        w_ctrl = w_isC ? instruction[CTRL_HI:CTRL_LO] : 6'b000000;
        w_y    = (w_isC && instruction[BIT_A]) ? inM : r_a;
        w_jump = w_isC && jump_taken(instruction[JMP_HI:JMP_LO], w_zr, w_ng);
    end

    hack_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x   (r_d),
        .y   (w_y),
        .zx  (w_ctrl[5]),
        .nx  (w_ctrl[4]),
        .zy  (w_ctrl[3]),
        .ny  (w_ctrl[2]),
        .f   (w_ctrl[1]),
        .no  (w_ctrl[0]),
        .out (w_aluOut),
        .zr  (w_zr),
        .ng  (w_ng)
    );

    // A register: loaded by A-instructions or by a C-instruction with dA set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
        end else if (w_exec) begin
            if (!w_isC) begin
                r_a <= instruction;
            end else if (instruction[BIT_DA]) begin
                r_a <= w_aluOut;
            end
        end
    end

    // D register: loaded only by a C-instruction with dD set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= '0;
        end else if (w_exec && w_isC && instruction[BIT_DD]) begin
            r_d <= w_aluOut;
        end
    end

    // Jump target is always the pre-edge A, even when dA rewrites A this cycle.
    hack_pc #(
        .AWIDTH (AWIDTH)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_exec),
        .i_load (w_jump),
        .i_din  (r_a[AWIDTH-1:0]),
        .o_pc   (pc)
    );

    assign outM     = w_aluOut;
    assign addressM = r_a[AWIDTH-1:0];
    assign writeM   = rst_n & w_exec & w_isC & instruction[BIT_DM];

endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: self-checking bench for hack_cpu.
// Directed scenarios followed by random instructions, all compared against
// an instruction-level reference model of the Hack machine.
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    // Reference machine state
    logic [15:0] mA;
    logic [15:0] mD;
    logic [14:0] mPc;

    // Inputs of the instruction currently presented
    logic [15:0] pendInstr;
    logic [15:0] pendInM;
    logic        pendValid;

    int errorCount = 0;
    int checkCount = 0;

    hack_cpu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] refAlu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
        logic [15:0] xs, ys, r;
        xs = c[5] ? 16'd0 : x;
        if (c[4]) xs = ~xs;
        ys = c[3] ? 16'd0 : y;
        if (c[2]) ys = ~ys;
        r = c[1] ? xs + ys : xs & ys;
        if (c[0]) r = ~r;
        return r;
    endfunction

    function automatic logic [15:0] refCompute(input logic [15:0] instr, input logic [15:0] mem);
        if (!instr[15]) return mD & mA;
        return refAlu(mD, instr[12] ? mem : mA, instr[11:6]);
    endfunction

    function automatic logic effective(input logic valid);
`ifdef HACK_CPU_STALL_EN
        return valid;
`else
        return 1'b1 | valid;
`endif
    endfunction

    // Present one instruction after the falling edge and check combinational outputs.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] mem,
                                 input logic valid);
        logic [15:0] expOut;
        @(negedge clk);
        rst_n       = 1'b1;
        instruction = instr;
        inM         = mem;
        instr_valid = valid;
        pendInstr   = instr;
        pendInM     = mem;
        pendValid   = effective(valid);
        #1;
        expOut = refCompute(instr, mem);
        checkOutput("outM", outM, expOut);
        checkOutput("writeM", {15'd0, writeM}, {15'd0, pendValid & instr[15] & instr[3]});
        checkOutput("addressM", {1'b0, addressM}, {1'b0, mA[14:0]});
        checkOutput("pc", {1'b0, pc}, {1'b0, mPc});
    endtask

    // Let the rising edge happen and advance the reference machine by one instruction.
    task automatic advance();
        logic [15:0] res;
        logic        taken;
        logic signed [15:0] sres;
        @(posedge clk);
        if (pendValid) begin
            if (!pendInstr[15]) begin
                mA  = pendInstr;
                mPc = mPc + 15'd1;
            end else begin
                res   = refCompute(pendInstr, pendInM);
                sres  = res;
                taken = (pendInstr[2] && sres < 0) || (pendInstr[1] && sres == 0) ||
                        (pendInstr[0] && sres > 0);
                mPc   = taken ? mA[14:0] : mPc + 15'd1;
                if (pendInstr[5]) mA = res;
                if (pendInstr[4]) mD = res;
            end
        end
    endtask

    task automatic step(input logic [15:0] instr, input logic [15:0] mem);
        applyStimulus(instr, mem, 1'b1);
        advance();
    endtask

    initial begin
        logic [14:0] savedPc;
        logic [15:0] rInstr;

        // Power-on reset with a memory-writing instruction held on the bus
        rst_n       = 1'b0;
        instruction = 16'hE308;
        inM         = 16'h0000;
        instr_valid = 1'b1;
        mA = 16'd0; mD = 16'd0; mPc = 15'd0;
        #3;
        checkOutput("rst_writeM", {15'd0, writeM}, 16'h0000);
        checkOutput("rst_pc", {1'b0, pc}, 16'h0000);
        @(negedge clk);
        @(negedge clk);

        // Load/move: @21, D=A, M=D
        step(16'h0015, 16'h0000);
        step(16'hEC10, 16'h0000);
        applyStimulus(16'hE308, 16'h0000, 1'b1);
        checkOutput("move_pc", {1'b0, pc}, 16'h0002);
        checkOutput("move_outM", outM, 16'h0015);
        checkOutput("move_writeM", {15'd0, writeM}, 16'h0001);
        checkOutput("move_addressM", {1'b0, addressM}, 16'h0015);
        advance();

        // Memory increment: AM=M+1 writes at the old A
        step(16'h0100, 16'h0000);
        applyStimulus(16'hFDE8, 16'h7FFF, 1'b1);
        checkOutput("inc_outM", outM, 16'h8000);
        checkOutput("inc_writeM", {15'd0, writeM}, 16'h0001);
        checkOutput("inc_addressM", {1'b0, addressM}, 16'h0100);
        advance();
        applyStimulus(16'h0030, 16'h0000, 1'b1);
        checkOutput("inc_newA", {1'b0, addressM}, 16'h0000);
        advance();

        // D;JEQ taken with D=0
        step(16'hEA90, 16'h0000);
        step(16'hE302, 16'h0000);
        applyStimulus(16'h0005, 16'h0000, 1'b1);
        checkOutput("jeq_taken_pc", {1'b0, pc}, 16'h0030);
        advance();

        // D;JEQ not taken with D=5
        step(16'hEC10, 16'h0000);
        step(16'h0030, 16'h0000);
        savedPc = mPc;
        step(16'hE302, 16'h0000);
        applyStimulus(16'h0040, 16'h0000, 1'b1);
        checkOutput("jeq_fall_pc", {1'b0, pc}, {1'b0, savedPc + 15'd1});
        advance();

        // Unconditional jump, then wrap from the top of the address space
        step(16'hEA87, 16'h0000);
        applyStimulus(16'h7FFF, 16'h0000, 1'b1);
        checkOutput("jmp_pc", {1'b0, pc}, 16'h0040);
        advance();
        step(16'hEA87, 16'h0000);
        applyStimulus(16'h0055, 16'h0000, 1'b1);
        checkOutput("wrap_top_pc", {1'b0, pc}, 16'h7FFF);
        advance();
        applyStimulus(16'hEAA7, 16'h0000, 1'b1);
        checkOutput("wrap_pc", {1'b0, pc}, 16'h0000);
        advance();

        // A=0;JMP jumps to the old A while A becomes 0
        applyStimulus(16'h0041, 16'h0000, 1'b1);
        checkOutput("dA_jmp_pc", {1'b0, pc}, 16'h0055);
        checkOutput("dA_jmp_A", {1'b0, addressM}, 16'h0000);
        advance();

`ifdef HACK_CPU_STALL_EN
        // Stall: three invalid cycles hold everything, then one execution
        step(16'h0010, 16'h0000);
        step(16'hEC10, 16'h0000);
        savedPc = mPc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'hE308, 16'h0000, 1'b0);
            checkOutput("stall_writeM", {15'd0, writeM}, 16'h0000);
            checkOutput("stall_pc", {1'b0, pc}, {1'b0, savedPc});
            advance();
        end
        applyStimulus(16'hE308, 16'h0000, 1'b1);
        checkOutput("resume_writeM", {15'd0, writeM}, 16'h0001);
        advance();
        applyStimulus(16'h0000, 16'h0000, 1'b1);
        checkOutput("resume_pc", {1'b0, pc}, {1'b0, savedPc + 15'd1});
        advance();
`endif

        // Mid-run asynchronous reset with A=0x1234, pc=0x0042
        step(16'h0041, 16'h0000);
        step(16'hEA87, 16'h0000);
        step(16'h0007, 16'h0000);
        step(16'hEC10, 16'h0000);
        step(16'h0041, 16'h0000);
        step(16'hEA87, 16'h0000);
        step(16'h1234, 16'h0000);
        applyStimulus(16'hE308, 16'h0000, 1'b1);
        checkOutput("pre_rst_pc", {1'b0, pc}, 16'h0042);
        #2;
        rst_n = 1'b0;
        mA = 16'd0; mD = 16'd0; mPc = 15'd0;
        #1;
        checkOutput("async_rst_pc", {1'b0, pc}, 16'h0000);
        checkOutput("async_rst_addressM", {1'b0, addressM}, 16'h0000);
        checkOutput("async_rst_writeM", {15'd0, writeM}, 16'h0000);
        checkOutput("async_rst_outM", outM, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        checkOutput("held_rst_pc", {1'b0, pc}, 16'h0000);

        // Random instruction stream against the reference model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3)
                rInstr = {1'b0, 15'($urandom)};
            else
                rInstr = {3'b111, 13'($urandom)};
            applyStimulus(rInstr, 16'($urandom), ($urandom_range(0, 4) != 0));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hack_cpu.md
# hack_cpu

Single-cycle Hack CPU core that sits directly upstream of `hack_alu`: it fetches nothing itself but decodes the 16-bit instruction word, holds the A, D and PC registers, and drives the ALU's x/y operands and six control bits (zx, nx, zy, ny, f, no). It consumes the ALU's out, zr and ng, and produces data-memory write and address signals plus the next instruction address. It connects between instruction ROM, data RAM and `hack_alu` inside the top-level Hack computer.

## Interface
Parameters:
- `WIDTH`, 16, data/instruction width; fixed by the Hack ISA, not intended to change.
- `AWIDTH`, 15, address width of pc and addressM.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `instruction`  input  16  current instruction from ROM at address `pc`.
- `instr_valid`  input  1  instruction word valid; low = stall (see Configuration).
- `inM`  input  16  data RAM read value at `addressM`.
- `outM`  output  16  ALU result; value to write to RAM.
- `writeM`  output  1  RAM write enable for this cycle.
- `addressM`  output  15  RAM address = A[14:0].
- `pc`  output  15  address of next instruction to fetch.

## Operation
- Decode: `instruction[15]`=0 is an A-instruction; =1 is a C-instruction. Fields: a=[12], zx..no=[11:6], dA=[5], dD=[4], dM=[3], j1=[2] (lt), j2=[1] (eq), j3=[0] (gt).
- A-instruction: A <= instruction; D unchanged; writeM=0; pc <= pc+1.
- C-instruction: ALU x = D; y = a ? inM : A; control bits passed through unmodified. If dA, A <= ALU out; if dD, D <= ALU out; writeM = dM.
- Jump taken = C & ((j1 & ng) | (j2 & zr) | (j3 & ~zr & ~ng)). Taken: pc <= A[14:0] (A value *before* this edge). Otherwise pc <= pc+1, wrapping 0x7FFF -> 0x0000.
- A-instruction drives ALU control bits to 0 (don't-care, but fixed for determinism).
- outM and addressM are combinational from current A, D, inM, instruction; addressM always uses pre-edge A even when dA is set.

## Timing
- Reset (rst_n low, any time, asynchronous): A=0, D=0, pc=0 immediately; writeM forced 0 while rst_n low. outM follows ALU combinationally (with A=D=0).
- Release: first instruction executed on the first rising edge with rst_n high; instruction at ROM[0] must already be presented.
- Latency: one instruction per cycle; register results are visible to the next instruction.
- Simultaneous dA with jump: jump target is old A; new A takes effect next cycle.
- Simultaneous dA and dM: RAM written at old A address with ALU out.
- Reset asserted mid-cycle aborts the instruction; no partial A/D/pc update survives.

## Configuration
- `HACK_CPU_STALL_EN` defined: `instr_valid` honoured; when low, A, D, pc hold and writeM=0; resumes on next cycle with instr_valid high, re-executing nothing.
- Undefined: `instr_valid` ignored (treated as 1); every edge out of reset executes an instruction.

## Structure
- Shared package `hack_pkg`: instruction field bit positions, `OP_C` bit index, jump-bit constants, `AWIDTH`/`WIDTH` constants.
- One sub-module: `hack_pc` (15-bit register with async reset, load, increment, hold/stall enable). `hack_alu` instantiated unchanged.

## Test plan
- Reset: drive rst_n low mid-run with A=0x1234, pc=0x0042 -> A=0, D=0, pc=0, writeM=0 immediately, without a clock edge.
- Load/move: 0x0015 (@21) then 0xEC10 (D=A) -> D=0x0015, pc=2; then 0xE308 (M=D) -> writeM=1, outM=0x0015, addressM=0x0015.
- Memory increment: A=0x0100, inM=0x7FFF, 0xFDE8 (AM=M+1) -> outM=0x8000, writeM=1, addressM=0x0100 same cycle; A=0x8000 after edge.
- Jumps: A=0x0030, D=0, 0xE302 (D;JEQ) -> pc=0x0030; with D=5 -> pc=old+1; 0xEA87 (0;JMP) -> pc=A unconditionally.
- PC wrap: pc=0x7FFF, A-instruction -> pc=0x0000.
- Stall (macro defined): instr_valid=0 for 3 cycles during 0xE308 -> writeM=0, pc/A/D constant; instr_valid=1 -> executes once, pc advances by 1.
